gauss_sample_buffer: RTL

GAUSS_SAMPLE_BUFFER -- requirements
Module: gauss_sample_buffer

---
 rtl/gauss_sample_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/gauss_sample_buffer.sv
// Aligns multiplier products with their valid, converts Q8.23 products to
// saturated Q4.11 samples and buffers them in a first-word-fall-through FIFO.
module gauss_sample_buffer #(
  parameter int unsigned LATENCY = 5,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                prod_in32bit,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [15:0]                out_data16bit,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [LATENCY-1:0] vld_sr;
  logic               aligned_valid_c;
  logic               conv_valid;
  logic [15:0]        conv_data;
  logic [15:0]        sat_c;
  logic signed [32:0] sum_c;
  logic signed [32:0] shr_c;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full_c;
  logic          rd_c;
  logic          wr_acc_c;
  logic          drop_c;

  assign aligned_valid_c = vld_sr[LATENCY-1];

  // Valid delay line matching the multiplier pipeline depth
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Round half-up by 2^11, shift down by 12, then clamp to 16-bit signed
  always_comb begin
    sum_c = $signed({prod_in32bit[31], prod_in32bit}) + 33'sd2048;
    shr_c = sum_c >>> 12;
    sat_c = shr_c[15:0];
    if (shr_c > 33'sd32767) begin
      sat_c = 16'h7fff;
    end else if (shr_c < -33'sd32768) begin
      sat_c = 16'h8000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_valid <= 1'b0;
      conv_data  <= '0;
    end else begin
      conv_valid <= aligned_valid_c;
      if (aligned_valid_c) begin
        conv_data <= sat_c;
      end
    end
  end

  // A write into a full FIFO is only accepted when the head leaves in the same edge
  always_comb begin
    full_c   = (level == LW'(DEPTH));
    rd_c     = out_valid && out_ready;
    wr_acc_c = conv_valid && (!full_c || rd_c);
    drop_c   = conv_valid && full_c && !rd_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_acc_c, rd_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= conv_data;
    end
  end

  // Output is forced to zero while empty so stale storage never shows after reset
  assign out_valid     = (level != '0);
  assign out_data16bit = out_valid ? mem[rd_ptr] : 16'h0000;

endmodule
